// File: rtl/ahb_cmd_arbiter_pkg.sv
// Shared types and constants for the two-requester AHB command arbiter.
package ahb_cmd_pkg;

  // Default number of WAIT cycles before a forced error response.
  localparam int unsigned TIMEOUT_DEFAULT = 64;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  // Requester identifier: 0 = r0, 1 = r1.
  typedef logic req_id_t;

endpackage

// File: rtl/ahb_cmd_arbiter_rr_arb2.sv
// Two-way round-robin winner selection: a lone requester wins, and on a tie
// the requester that was not granted last wins.
module rr_arb2
  import ahb_cmd_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last_id,
  output req_id_t    grant_id,
  output logic       valid
);

  // Pick the winner from the request pair and the last-grant pointer.
  always_comb begin
    grant_id = 1'b0;
    valid    = 1'b0;
    case (req)
      2'b01: begin
        grant_id = 1'b0;
        valid    = 1'b1;
      end
      2'b10: begin
        grant_id = 1'b1;
        valid    = 1'b1;
      end
      2'b11: begin
        grant_id = ~last_id;
        valid    = 1'b1;
      end
      default: begin
        grant_id = 1'b0;
        valid    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ahb_cmd_arbiter.sv
// Arbitrates two command requesters onto a single ahb_top command port.
// One transaction at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
module ahb_cmd_arbiter
  import ahb_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        r0_req,
  input  logic        r1_req,
  input  logic        r0_write,
  input  logic        r1_write,
  input  logic        r0_burst,
  input  logic        r1_burst,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r0_wdata,
  input  logic [31:0] r1_wdata,
  input  logic        r0_nonsec,
  input  logic        r1_nonsec,
  output logic        r0_done,
  output logic        r1_done,
  output logic        r0_error,
  output logic        r1_error,
  output logic [31:0] r0_rdata,
  output logic [31:0] r1_rdata,
  output logic        busy,
  output logic        cmd_start,
  output logic        cmd_write,
  output logic        cmd_burst,
  output logic        cmd_sec,
  output logic [31:0] cmd_addr,
  output logic [31:0] cmd_wdata,
  input  logic        cmd_done,
  input  logic        cmd_error,
  input  logic [31:0] cmd_rdata
);

  // Wide enough to hold TIMEOUT-1; the counter saturates there, so it never wraps.
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  arb_state_e       state_q, state_d;
  req_id_t          last_q, last_d;
  req_id_t          gnt_q, gnt_d;
  logic             write_q, write_d;
  logic             burst_q, burst_d;
  logic             sec_q, sec_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  req_id_t arb_gnt_s;
  logic    arb_valid_s;

  rr_arb2 u_rr_arb2 (
    .req      ({r1_req, r0_req}),
    .last_id  (last_q),
    .grant_id (arb_gnt_s),
    .valid    (arb_valid_s)
  );

  // Next-state, field latching and timeout counting for the command FSM.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    write_d = write_q;
    burst_d = burst_q;
    sec_d   = sec_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid_s) begin
          gnt_d   = arb_gnt_s;
          write_d = arb_gnt_s ? r1_write  : r0_write;
          burst_d = arb_gnt_s ? r1_burst  : r0_burst;
          sec_d   = arb_gnt_s ? r1_nonsec : r0_nonsec;
          addr_d  = arb_gnt_s ? r1_addr   : r0_addr;
          wdata_d = arb_gnt_s ? r1_wdata  : r0_wdata;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cmd_done) begin
          rdata_d = cmd_rdata;
          err_d   = cmd_error;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_MAX) begin
          rdata_d = 32'h0000_0000;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_RESP: begin
        last_d  = gnt_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset leaves r0 preferred (last grant = r1).
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      write_q <= 1'b0;
      burst_q <= 1'b0;
      sec_q   <= 1'b0;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      rdata_q <= 32'h0000_0000;
      err_q   <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      write_q <= write_d;
      burst_q <= burst_d;
      sec_q   <= sec_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are plain decodes of registered state; nothing reaches them from inputs.
  assign busy      = (state_q != ST_IDLE);
  assign cmd_start = (state_q == ST_ISSUE);
  assign cmd_burst = (state_q == ST_ISSUE) & burst_q;
  assign cmd_write = write_q;
  assign cmd_sec   = sec_q;
  assign cmd_addr  = addr_q;
  assign cmd_wdata = wdata_q;

  assign r0_done   = (state_q == ST_RESP) & (gnt_q == 1'b0);
  assign r1_done   = (state_q == ST_RESP) & (gnt_q == 1'b1);
  assign r0_error  = r0_done & err_q;
  assign r1_error  = r1_done & err_q;
  assign r0_rdata  = r0_done ? rdata_q : 32'h0000_0000;
  assign r1_rdata  = r1_done ? rdata_q : 32'h0000_0000;

endmodule

// File: tb/tb_ahb_cmd_arbiter.sv
// Self-checking bench for ahb_cmd_arbiter: transaction-level reference model,
// a memory-backed ahb_top stub, directed table, hand sequences and random traffic.
module tb_ahb_cmd_arbiter;

  localparam int T = 8;

  logic        hclk, hreset;
  logic        r0_req, r1_req, r0_write, r1_write, r0_burst, r1_burst;
  logic [31:0] r0_addr, r1_addr, r0_wdata, r1_wdata;
  logic        r0_nonsec, r1_nonsec;
  logic        r0_done, r1_done, r0_error, r1_error;
  logic [31:0] r0_rdata, r1_rdata;
  logic        busy, cmd_start, cmd_write, cmd_burst, cmd_sec;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        cmd_done, cmd_error;
  logic [31:0] cmd_rdata;

  ahb_cmd_arbiter #(.TIMEOUT(T)) dut (
    .hclk(hclk), .hreset(hreset),
    .r0_req(r0_req), .r1_req(r1_req),
    .r0_write(r0_write), .r1_write(r1_write),
    .r0_burst(r0_burst), .r1_burst(r1_burst),
    .r0_addr(r0_addr), .r1_addr(r1_addr),
    .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
    .r0_nonsec(r0_nonsec), .r1_nonsec(r1_nonsec),
    .r0_done(r0_done), .r1_done(r1_done),
    .r0_error(r0_error), .r1_error(r1_error),
    .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
    .busy(busy), .cmd_start(cmd_start),
    .cmd_write(cmd_write), .cmd_burst(cmd_burst), .cmd_sec(cmd_sec),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_done(cmd_done), .cmd_error(cmd_error), .cmd_rdata(cmd_rdata)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    logic        id;
    logic        write;
    logic        burst;
    logic        nonsec;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } rec_t;

  typedef struct {
    logic        id;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } obs_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state (transaction level).
  int          cyc, idle_from, st_c, rsp_c, gnt_cyc, t_lat, next_lat;
  bit          t_valid, stray;
  logic        last_id;
  logic        m_gnt, m_write, m_burst, m_sec, m_err;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [31:0] mem_m [64];

  // ahb_top stub state.
  logic [31:0] mem_s [64];
  logic [31:0] s_rdata;
  logic        s_err;
  bit          s_live;
  int          s_due;

  // Requester drive values.
  logic [1:0]  d_req;
  logic        d_write [2];
  logic        d_burst [2];
  logic        d_sec   [2];
  logic [31:0] d_addr  [2];
  logic [31:0] d_wdata [2];

  obs_t obs_q[$];

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_bound(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired, got no event expected one (cycle %0d)", name, cyc);
  endtask

  // ahb_top behaviour: nonsec is refused with an error; writes store 1 or 4
  // incrementing words; reads return the addressed word.
  task automatic env_access(input bit sel, input logic wr, input logic bu, input logic se,
                            input logic [31:0] ad, input logic [31:0] wd,
                            output logic [31:0] rd, output logic er);
    int idx;
    idx = int'(ad[7:2]);
    rd = 32'h0;
    er = 1'b0;
    if (se) begin
      er = 1'b1;
    end else if (wr) begin
      for (int k = 0; k < (bu ? 4 : 1); k++) begin
        if (sel) mem_s[(idx + k) % 64] = wd + 32'(k);
        else     mem_m[(idx + k) % 64] = wd + 32'(k);
      end
    end else begin
      rd = sel ? mem_s[idx] : mem_m[idx];
    end
  endtask

  task automatic drive_inputs();
    r0_req = d_req[0];   r1_req = d_req[1];
    r0_write = d_write[0]; r1_write = d_write[1];
    r0_burst = d_burst[0]; r1_burst = d_burst[1];
    r0_nonsec = d_sec[0];  r1_nonsec = d_sec[1];
    r0_addr = d_addr[0];   r1_addr = d_addr[1];
    r0_wdata = d_wdata[0]; r1_wdata = d_wdata[1];
  endtask

  task automatic model_reset();
    t_valid = 1'b0; idle_from = 0; last_id = 1'b1; stray = 1'b0;
    m_gnt = 1'b0; m_write = 1'b0; m_burst = 1'b0; m_sec = 1'b0; m_err = 1'b0;
    m_addr = 32'h0; m_wdata = 32'h0; m_rdata = 32'h0;
    s_live = 1'b0; s_due = 0;
    cmd_done = 1'b0; cmd_error = 1'b0; cmd_rdata = 32'h0;
    d_req = 2'b00;
    for (int i = 0; i < 2; i++) begin
      d_write[i] = 1'b0; d_burst[i] = 1'b0; d_sec[i] = 1'b0;
      d_addr[i] = 32'h0; d_wdata[i] = 32'h0;
    end
    drive_inputs();
    obs_q.delete();
  endtask

  function automatic logic [159:0] all_outputs();
    return {23'h0, busy, cmd_start, cmd_burst, cmd_write, cmd_sec,
            r0_done, r1_done, r0_error, r1_error,
            r0_rdata, r1_rdata, cmd_addr, cmd_wdata};
  endfunction

  task automatic do_reset();
    hreset = 1'b1;
    model_reset();
    repeat (3) @(negedge hclk);
    check("reset_outputs", all_outputs(), 160'h0);
    hreset = 1'b0;
    cyc = -1;
  endtask

  // One clock cycle: check outputs against the model, run the stub, drive the
  // requesters, and let the model grant if it is idle.
  task automatic step();
    bit in_t, st_e, rsp_e, wait_e, w;
    logic [159:0] ctrl_e, data_e;
    obs_t o;
    @(negedge hclk);
    cyc++;
    in_t   = t_valid && cyc >= st_c && cyc <= rsp_c;
    st_e   = t_valid && cyc == st_c;
    rsp_e  = t_valid && cyc == rsp_c;
    wait_e = t_valid && cyc > st_c && cyc < rsp_c;
    ctrl_e = 160'({in_t, st_e, st_e & m_burst, m_write, m_sec,
                   rsp_e & ~m_gnt, rsp_e & m_gnt, rsp_e & ~m_gnt & m_err, rsp_e & m_gnt & m_err});
    data_e = 160'({(rsp_e && !m_gnt) ? m_rdata : 32'h0, (rsp_e && m_gnt) ? m_rdata : 32'h0,
                   m_addr, m_wdata});
    check("ctrl", 160'({busy, cmd_start, cmd_burst, cmd_write, cmd_sec,
                        r0_done, r1_done, r0_error, r1_error}), ctrl_e);
    check("data", 160'({r0_rdata, r1_rdata, cmd_addr, cmd_wdata}), data_e);
    if (r0_done || r1_done) begin
      o.id = r1_done;
      o.rdata = r1_done ? r1_rdata : r0_rdata;
      o.err = r1_done ? r1_error : r0_error;
      o.cyc = cyc;
      obs_q.push_back(o);
    end
    if (cmd_start) begin
      env_access(1'b1, cmd_write, cmd_burst, cmd_sec, cmd_addr, cmd_wdata, s_rdata, s_err);
      s_live = (t_lat <= T);
      s_due = cyc + t_lat;
    end
    if (s_live && cyc == s_due) begin
      cmd_done = 1'b1; cmd_rdata = s_rdata; cmd_error = s_err; s_live = 1'b0;
    end else if (stray && !wait_e) begin
      cmd_done = 1'b1; cmd_rdata = 32'hBAD0_BAD0; cmd_error = 1'b1;
    end else begin
      cmd_done = 1'b0; cmd_rdata = 32'h0; cmd_error = 1'b0;
    end
    drive_inputs();
    if (cyc >= idle_from && d_req != 2'b00) begin
      w = (d_req == 2'b11) ? ~last_id : d_req[1];
      last_id = w;
      gnt_cyc = cyc;
      t_lat = next_lat;
      t_valid = 1'b1;
      st_c = cyc + 1;
      rsp_c = st_c + ((t_lat <= T) ? t_lat : T) + 1;
      idle_from = rsp_c + 1;
      m_gnt = w; m_write = d_write[w]; m_burst = d_burst[w]; m_sec = d_sec[w];
      m_addr = d_addr[w]; m_wdata = d_wdata[w];
      env_access(1'b0, m_write, m_burst, m_sec, m_addr, m_wdata, m_rdata, m_err);
      if (t_lat > T) begin
        m_rdata = 32'h0;
        m_err = 1'b1;
      end
    end
  endtask

  task automatic drain(input string name);
    d_req = 2'b00;
    stray = 1'b0;
    for (int k = 0; k < 60 && cyc < idle_from; k++) step();
    if (cyc < idle_from) fail_bound(name);
  endtask

  task automatic run_rec(input string name, input rec_t r);
    obs_t o;
    d_req = 2'b00;
    d_req[r.id] = 1'b1;
    d_write[r.id] = r.write; d_burst[r.id] = r.burst; d_sec[r.id] = r.nonsec;
    d_addr[r.id] = r.addr;   d_wdata[r.id] = r.wdata;
    next_lat = r.lat;
    obs_q.delete();
    step();
    d_req = 2'b00;
    for (int k = 0; k < 40 && obs_q.size() == 0; k++) step();
    if (obs_q.size() == 0) begin
      fail_bound(name);
    end else begin
      o = obs_q[0];
      check(name, 160'({o.id, o.rdata, o.err, 32'(o.cyc - gnt_cyc)}),
                  160'({r.id, r.exp_rdata, r.exp_err, 32'(r.exp_lat)}));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t tbl [10];
    rec_t post;
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 32'hCAFEBABE, 2,  32'h0,        1'b0, 4};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 32'h0,       2,  32'hCAFEBABE, 1'b0, 4};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h04, 32'hDEADBEEF, 3, 32'h0,        1'b1, 5};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h00, 32'h10,      4,  32'h0,        1'b0, 6};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 32'h0,       1,  32'h10,       1'b0, 3};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h04, 32'h0,       1,  32'h11,       1'b0, 3};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h08, 32'h0,       1,  32'h12,       1'b0, 3};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0C, 32'h0,       1,  32'h13,       1'b0, 3};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0,       20, 32'h0,        1'b1, 10};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 32'h0,       T,  32'h10,       1'b0, 10};
    post   = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h08, 32'h0,       2,  32'h12,       1'b0, 4};

    for (int i = 0; i < 64; i++) begin
      mem_m[i] = 32'h0;
      mem_s[i] = 32'h0;
    end
    cyc = -1; next_lat = 2; t_lat = 2; gnt_cyc = 0; st_c = 0; rsp_c = 0;
    do_reset();

    // Directed transactions: write/read-back, nonsec error, burst, timeout boundary.
    for (int i = 0; i < 10; i++) run_rec($sformatf("table_%0d", i), tbl[i]);

    // Both requesters held high after reset: grants alternate starting with r0.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      d_write[i] = 1'b0; d_burst[i] = 1'b0; d_sec[i] = 1'b0;
      d_addr[i] = 32'h0; d_wdata[i] = 32'h0;
    end
    d_req = 2'b11;
    next_lat = 2;
    for (int k = 0; k < 80 && obs_q.size() < 4; k++) step();
    for (int i = 0; i < 4; i++) begin
      if (obs_q.size() > i) check($sformatf("alternate_%0d", i), 160'(obs_q[i].id), 160'(i % 2));
      else fail_bound($sformatf("alternate_%0d", i));
    end
    drain("alternate_drain");

    // Reset in the middle of WAIT: outputs clear at once, no done, then normal service.
    do_reset();
    d_req = 2'b01;
    d_write[0] = 1'b0; d_burst[0] = 1'b0; d_sec[0] = 1'b0;
    d_addr[0] = 32'h80; d_wdata[0] = 32'h0;
    next_lat = 20;
    step();
    d_req = 2'b00;
    repeat (3) step();
    check("busy_before_reset", 160'(busy), 160'(1'b1));
    #2 hreset = 1'b1;
    #1 check("async_reset_outputs", all_outputs(), 160'h0);
    model_reset();
    repeat (2) @(negedge hclk);
    check("held_reset_outputs", all_outputs(), 160'h0);
    hreset = 1'b0;
    cyc = -1;
    run_rec("post_reset_read", post);

    // Random traffic with stray cmd_done outside WAIT.
    for (int k = 0; k < 500; k++) begin
      d_req = 2'($urandom);
      for (int i = 0; i < 2; i++) begin
        d_write[i] = 1'($urandom);
        d_burst[i] = 1'($urandom);
        d_sec[i]   = ($urandom % 8 == 0);
        d_addr[i]  = {24'h0, 6'($urandom), 2'b00};
        d_wdata[i] = $urandom;
      end
      next_lat = int'($urandom_range(1, T + 3));
      stray = ($urandom % 4 == 0);
      step();
    end
    drain("random_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
